// File: rtl/nco_pitch_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : nco_pitch_sync_gen
// Brief    : Scans NCO voice/oscillator slots, emitting per-slot phase
//            increment and note-on phase-zero requests.
// Revision : 1.0
// ============================================================================
module nco_pitch_sync_gen #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_ENVS  = 8,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic               sCLK_XVXENVS,
  input  logic               reset_reg_N,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [V_WIDTH-1:0] note_voice,
  input  logic [6:0]         note_key,
  input  logic               note_gate,
  input  logic               cfg_we,
  input  logic [O_WIDTH-1:0] cfg_osc,
  input  logic [6:0]         cfg_coarse,
  input  logic [7:0]         cfg_fine,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic [23:0]        osc_pitch_val,
  output logic [V_ENVS-1:0]  osc_accum_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2} sync_state_t;

  localparam logic [V_WIDTH-1:0] c_last_voice = V_WIDTH'(VOICES - 1);
  localparam logic [O_WIDTH-1:0] c_last_osc   = O_WIDTH'(V_OSC - 1);

  function automatic logic [23:0] base_lut(input logic [3:0] s);
    case (s)
      4'd1:    base_lut = 24'h879C7D;
      4'd2:    base_lut = 24'h8FACD6;
      4'd3:    base_lut = 24'h9837F0;
      4'd4:    base_lut = 24'hA14518;
      4'd5:    base_lut = 24'hAADC08;
      4'd6:    base_lut = 24'hB504F3;
      4'd7:    base_lut = 24'hBFC887;
      4'd8:    base_lut = 24'hCB2FF5;
      4'd9:    base_lut = 24'hD744FD;
      4'd10:   base_lut = 24'hE411F0;
      4'd11:   base_lut = 24'hF1A1BF;
      default: base_lut = 24'h800000;
    endcase
  endfunction

  logic [V_WIDTH-1:0] r_vx_c, w_next_vx;
  logic [O_WIDTH-1:0] r_ox_c;
  logic               w_slot_end, r_ready, w_acc;
  logic [6:0]         r_key    [VOICES];
  logic [6:0]         r_coarse [V_OSC];
  logic [7:0]         r_fine   [V_OSC];
  sync_state_t        r_state     [VOICES];
  sync_state_t        w_state_nxt [VOICES];
  logic [VOICES-1:0]  r_pend, w_pend_nxt, w_on, w_start, w_end;
  logic [V_ENVS-1:0]  w_zero_mask;

  assign w_slot_end = (r_ox_c == c_last_osc);
  assign w_next_vx  = (r_vx_c == c_last_voice) ? '0 : r_vx_c + 1'b1;
  assign w_acc      = note_valid & r_ready;
  assign note_ready = r_ready;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_vx_c  <= '0;
      r_ox_c  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_ox_c  <= w_slot_end ? '0 : r_ox_c + 1'b1;
      if (w_slot_end) r_vx_c <= w_next_vx;
      r_ready <= ~w_acc;
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++) r_key[v] <= '0;
      for (int o = 0; o < V_OSC; o++) begin
        r_coarse[o] <= '0;
        r_fine[o]   <= '0;
      end
    end else begin
      if (w_acc) r_key[note_voice] <= note_key;
      if (cfg_we) begin
        r_coarse[cfg_osc] <= cfg_coarse;
        r_fine[cfg_osc]   <= cfg_fine;
      end
    end
  end

  // w_start fires on the edge that moves the counter onto (v,0), so the
  // stage-1 fetch of every slot of that pass already sees ACTIVE.
  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    assign w_on[v]    = w_acc & note_gate & (note_voice == V_WIDTH'(v));
    assign w_start[v] = w_slot_end & (w_next_vx == V_WIDTH'(v));
    assign w_end[v]   = w_slot_end & (r_vx_c == V_WIDTH'(v));
  end

  for (genvar e = 0; e < V_ENVS; e++) begin : g_zmask
    assign w_zero_mask[e] = ((e % 2) == 0) && ((e / 2) < V_OSC);
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++) r_state[v] <= IDLE;
      r_pend <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    for (int v = 0; v < VOICES; v++) begin
      if (w_on[v]) w_pend_nxt[v] = 1'b1;
      case (r_state[v])
        IDLE:    if (w_on[v]) w_state_nxt[v] = ARMED;
        ARMED:   if (w_start[v]) begin
                   w_state_nxt[v] = ACTIVE;
                   w_pend_nxt[v]  = 1'b0;
                 end
        ACTIVE:  if (w_end[v]) w_state_nxt[v] = (r_pend[v] | w_on[v]) ? ARMED : IDLE;
        default: w_state_nxt[v] = IDLE;
      endcase
    end
  end

  logic [V_WIDTH-1:0] r_s1_vx, r_s2_vx;
  logic [O_WIDTH-1:0] r_s1_ox, r_s2_ox;
  logic [6:0]         r_s1_key, r_s1_coarse, w_k;
  logic [7:0]         r_s1_fine, r_s2_fine;
  logic               r_s1_zero, r_s2_zero;
  logic [3:0]         r_s2_oct, r_s2_semi;
  logic signed [8:0]  w_k_sum;
  logic [23:0]        w_base, w_inc, w_pitch;
  logic [31:0]        w_sum;

  always_comb begin
    w_k_sum = $signed({2'b00, r_s1_key}) + $signed({{2{r_s1_coarse[6]}}, r_s1_coarse});
    if (w_k_sum < 0)             w_k = '0;
    else if (w_k_sum > 9'sd127)  w_k = 7'd127;
    else                         w_k = w_k_sum[6:0];
  end

  // Fine detune scales the increment by (1 + fine/4096).
  always_comb begin
    w_base  = base_lut(r_s2_semi);
    w_inc   = w_base >> (4'd10 - r_s2_oct);
    w_sum   = {8'd0, w_inc} + (({8'd0, w_inc} * {24'd0, r_s2_fine}) >> 12);
    w_pitch = (w_sum > 32'h00FF_FFFF) ? 24'hFF_FFFF : w_sum[23:0];
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_s1_vx <= '0; r_s1_ox <= '0; r_s1_key <= '0; r_s1_coarse <= '0;
      r_s1_fine <= '0; r_s1_zero <= 1'b0;
      r_s2_vx <= '0; r_s2_ox <= '0; r_s2_oct <= '0; r_s2_semi <= '0;
      r_s2_fine <= '0; r_s2_zero <= 1'b0;
      vx <= '0; ox <= '0; osc_pitch_val <= '0; osc_accum_zero <= '0;
    end else begin
      r_s1_vx     <= r_vx_c;
      r_s1_ox     <= r_ox_c;
      r_s1_key    <= r_key[r_vx_c];
      r_s1_coarse <= r_coarse[r_ox_c];
      r_s1_fine   <= r_fine[r_ox_c];
      r_s1_zero   <= (r_state[r_vx_c] == ACTIVE);

      r_s2_vx   <= r_s1_vx;
      r_s2_ox   <= r_s1_ox;
      r_s2_oct  <= 4'(w_k / 7'd12);
      r_s2_semi <= 4'(w_k % 7'd12);
      r_s2_fine <= r_s1_fine;
      r_s2_zero <= r_s1_zero;

      vx             <= r_s2_vx;
      ox             <= r_s2_ox;
      osc_pitch_val  <= w_pitch;
      osc_accum_zero <= r_s2_zero ? w_zero_mask : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_pitch_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_pitch_sync_gen
// Brief    : Directed self-checking bench for nco_pitch_sync_gen.
// Revision : 1.0
// ============================================================================
module tb_nco_pitch_sync_gen;

  logic        sCLK_XVXENVS = 1'b0;
  logic        reset_reg_N;
  logic        note_valid, note_ready, note_gate, cfg_we;
  logic [2:0]  note_voice, vx;
  logic [6:0]  note_key, cfg_coarse;
  logic [1:0]  cfg_osc, ox;
  logic [7:0]  cfg_fine, osc_accum_zero;
  logic [23:0] osc_pitch_val;

  int vectors = 0;
  int miscompares = 0;
  int edges;

  nco_pitch_sync_gen dut (
    .sCLK_XVXENVS  (sCLK_XVXENVS),
    .reset_reg_N   (reset_reg_N),
    .note_valid    (note_valid),
    .note_ready    (note_ready),
    .note_voice    (note_voice),
    .note_key      (note_key),
    .note_gate     (note_gate),
    .cfg_we        (cfg_we),
    .cfg_osc       (cfg_osc),
    .cfg_coarse    (cfg_coarse),
    .cfg_fine      (cfg_fine),
    .vx            (vx),
    .ox            (ox),
    .osc_pitch_val (osc_pitch_val),
    .osc_accum_zero(osc_accum_zero)
  );

  always #5 sCLK_XVXENVS = ~sCLK_XVXENVS;

  // Rising edges since reset release; the slot counter value is edges % 32.
  always @(posedge sCLK_XVXENVS or negedge reset_reg_N)
    if (!reset_reg_N) edges <= 0;
    else              edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge sCLK_XVXENVS);
  endtask

  task automatic goto_slot(input int c);
    int guard = 0;
    while ((edges % 32) != c && guard < 64) begin
      step();
      guard++;
    end
    chk("goto_slot", 32'(guard < 64), 32'd1);
  endtask

  task automatic note(input int v, input int key, input logic gate);
    note_valid = 1'b1;
    note_voice = 3'(v);
    note_key   = 7'(key);
    note_gate  = gate;
    step();
    note_valid = 1'b0;
    chk("ready_low_after_accept", 32'(note_ready), 32'd0);
    step();
    chk("ready_back_high", 32'(note_ready), 32'd1);
  endtask

  task automatic cfg(input int o, input logic [6:0] coarse, input logic [7:0] fine);
    cfg_we     = 1'b1;
    cfg_osc    = 2'(o);
    cfg_coarse = coarse;
    cfg_fine   = fine;
    step();
    cfg_we     = 1'b0;
  endtask

  // Checks the next complete presented pass of voice v.
  task automatic pass_check(input int v, input logic [23:0] p0, input logic [23:0] p1,
                            input logic [23:0] p2, input logic [23:0] p3, input logic [7:0] z);
    logic [23:0] p [4];
    int guard = 0;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    repeat (4) step();
    while (!(vx == 3'(v) && ox == 2'd0) && guard < 48) begin
      step();
      guard++;
    end
    chk("pass_align", 32'(guard < 48), 32'd1);
    for (int o = 0; o < 4; o++) begin
      chk($sformatf("slot_vx v%0d o%0d", v, o), 32'(vx), 32'(v));
      chk($sformatf("slot_ox v%0d o%0d", v, o), 32'(ox), 32'(o));
      chk($sformatf("pitch v%0d o%0d", v, o), 32'(osc_pitch_val), 32'(p[o]));
      chk($sformatf("zero v%0d o%0d", v, o), 32'(osc_accum_zero), 32'(z));
      step();
    end
  endtask

  initial begin
    int s;
    reset_reg_N = 1'b0;
    note_valid = 1'b0; note_voice = '0; note_key = '0; note_gate = 1'b0;
    cfg_we = 1'b0; cfg_osc = '0; cfg_coarse = '0; cfg_fine = '0;
    #12;
    chk("reset_vx", 32'(vx), 32'd0);
    chk("reset_ox", 32'(ox), 32'd0);
    chk("reset_pitch", 32'(osc_pitch_val), 32'd0);
    chk("reset_zero", 32'(osc_accum_zero), 32'd0);
    chk("reset_ready", 32'(note_ready), 32'd1);
    step();
    reset_reg_N = 1'b1;

    // Idle scan: slot order, period 32, key 0 pitch everywhere.
    for (int k = 1; k <= 38; k++) begin
      step();
      if (edges >= 3) begin
        s = (edges - 3) % 32;
        chk("idle_vx", 32'(vx), 32'(s / 4));
        chk("idle_ox", 32'(ox), 32'(s % 4));
        chk("idle_pitch", 32'(osc_pitch_val), 32'h2000);
        chk("idle_zero", 32'(osc_accum_zero), 32'd0);
      end
    end

    // Note-on voice 2, key 60: one zero pass, then none.
    goto_slot(0);
    note(2, 60, 1'b1);
    pass_check(2, 24'h040000, 24'h040000, 24'h040000, 24'h040000, 8'h55);
    pass_check(2, 24'h040000, 24'h040000, 24'h040000, 24'h040000, 8'h00);

    // Fine detune on osc 1 at octave 10 and octave 5.
    note(0, 120, 1'b0);
    cfg(1, 7'd0, 8'd255);
    pass_check(0, 24'h800000, 24'h87F800, 24'h800000, 24'h800000, 8'h00);
    pass_check(2, 24'h040000, 24'h043FC0, 24'h040000, 24'h040000, 8'h00);

    // Upper clamp: key 127 + coarse +63 on osc 2.
    note(1, 127, 1'b0);
    cfg(2, 7'd63, 8'd0);
    pass_check(1, 24'hBFC887, 24'hCBB912, 24'hBFC887, 24'hBFC887, 8'h00);

    // Lower clamp: key 10 + coarse -64 on osc 3.
    note(3, 10, 1'b0);
    cfg(3, 7'h40, 8'd0);
    pass_check(3, 24'h003904, 24'h003C90, 24'h0879C7, 24'h002000, 8'h00);

    // Note-on for voice 5 accepted while slot (5,2) is fetched.
    goto_slot(22);
    note(5, 0, 1'b1);
    step();
    chk("late_arm_slot_ox", 32'(ox), 32'd2);
    chk("late_arm_zero_o2", 32'(osc_accum_zero), 32'd0);
    step();
    chk("late_arm_zero_o3", 32'(osc_accum_zero), 32'd0);
    pass_check(5, 24'h002000, 24'h0021FE, 24'h04C1BF, 24'h002000, 8'h55);
    pass_check(5, 24'h002000, 24'h0021FE, 24'h04C1BF, 24'h002000, 8'h00);

    // Asynchronous reset while voice 6 is ACTIVE.
    goto_slot(0);
    note(6, 60, 1'b1);
    goto_slot(30);
    chk("pre_reset_vx", 32'(vx), 32'd6);
    chk("pre_reset_zero", 32'(osc_accum_zero), 32'h55);
    #1 reset_reg_N = 1'b0;
    #1;
    chk("async_reset_vx", 32'(vx), 32'd0);
    chk("async_reset_ox", 32'(ox), 32'd0);
    chk("async_reset_pitch", 32'(osc_pitch_val), 32'd0);
    chk("async_reset_zero", 32'(osc_accum_zero), 32'd0);
    step();
    reset_reg_N = 1'b1;
    pass_check(6, 24'h002000, 24'h002000, 24'h002000, 24'h002000, 8'h00);
    pass_check(2, 24'h002000, 24'h002000, 24'h002000, 24'h002000, 8'h00);
    pass_check(6, 24'h002000, 24'h002000, 24'h002000, 24'h002000, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
